lru_replacer_pipe: RTL

//  Parametrised true-LRU replacement engine for the set-associative data cache; successor to the fixed 8x4 LRU.

---
 rtl/lru_replacer_pipe_pkg.sv | 29 ++
 rtl/lru_rank_update.sv | 27 ++
 rtl/lru_replacer_pipe.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lru_replacer_pipe_pkg.sv
// Shared types and per-way rank helpers for the true-LRU replacement engine.
package lru_pkg;

  typedef enum logic [1:0] {
    OP_ACCESS = 2'd0,
    OP_INVAL  = 2'd1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Rank 0 is most recent; a touched way jumps to 0 and everything younger ages by one.
  function automatic int rank_touch(input int cur, input int old, input bit self);
    if (self)           return 0;
    else if (cur < old) return cur + 1;
    else                return cur;
  endfunction

  // An invalidated way becomes the oldest; everything older than it moves up one.
  function automatic int rank_inval(input int cur, input int old, input bit self, input int last);
    if (self)           return last;
    else if (cur > old) return cur - 1;
    else                return cur;
  endfunction

endpackage

// File: rtl/lru_rank_update.sv
// Combinational next-rank computation for one set: touch or invalidate a single way.
module lru_rank_update
  import lru_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] i_rank,
  input  logic [WAY_W-1:0]               i_way,
  input  logic                           i_inval,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] o_rank
);

  logic [WAY_W-1:0] w_old;
  assign w_old = i_rank[i_way];

  always_comb begin
    o_rank = i_rank;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (i_inval)
        o_rank[w] = WAY_W'(rank_inval(int'(i_rank[w]), int'(w_old), i_way == WAY_W'(w), NUM_WAYS - 1));
      else
        o_rank[w] = WAY_W'(rank_touch(int'(i_rank[w]), int'(w_old), i_way == WAY_W'(w)));
    end
  end

endmodule

// File: rtl/lru_replacer_pipe.sv
// True-LRU replacement engine: IDLE -> CALC -> RESP, one request in flight.
// Optional hit/miss/evict counters are built when LRU_STATS_EN is defined.
module lru_replacer_pipe
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_hit,
  input  logic [WAY_W-1:0] req_way,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WAY_W-1:0] resp_way,
  output logic             resp_evict,
  output logic             resp_err
`ifdef LRU_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_evicts
`endif
);

  state_e r_state, w_next;

  logic             r_inval;
  logic [SET_W-1:0] r_set;
  logic             r_hit;
  logic [WAY_W-1:0] r_way;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] r_rank;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            r_valid;

  logic [WAY_W-1:0] r_resp_way;
  logic             r_resp_evict;
  logic             r_resp_err;

  logic [NUM_WAYS-1:0][WAY_W-1:0] w_rank, w_rank_new;
  logic [NUM_WAYS-1:0]            w_vld, w_vld_new;
  logic                           w_free_found;
  logic [WAY_W-1:0]               w_free_way, w_old_way, w_sel;
  logic                           w_err, w_evict, w_upd;
  logic                           w_accept;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_way   = r_resp_way;
  assign resp_evict = r_resp_evict;
  assign resp_err   = r_resp_err;
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reserved opcodes fall through as accesses, so only OP_INVAL is decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inval <= 1'b0;
      r_set   <= '0;
      r_hit   <= 1'b0;
      r_way   <= '0;
    end else if (w_accept) begin
      r_inval <= (req_op == OP_INVAL);
      r_set   <= req_set;
      r_hit   <= req_hit;
      r_way   <= req_way;
    end
  end

  assign w_rank = r_rank[r_set];
  assign w_vld  = r_valid[r_set];

  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_vld[w]) begin
        w_free_found = 1'b1;
        w_free_way   = WAY_W'(w);
      end
    end
    w_old_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (w_rank[w] == WAY_W'(NUM_WAYS - 1)) w_old_way = WAY_W'(w);
  end

  always_comb begin
    w_sel   = r_way;
    w_err   = 1'b0;
    w_evict = 1'b0;
    w_upd   = 1'b1;
    if (!r_inval) begin
      if (r_hit) begin
        if (!w_vld[r_way]) begin
          w_err = 1'b1;
          w_upd = 1'b0;
        end
      end else if (w_free_found) begin
        w_sel = w_free_way;
      end else begin
        w_sel   = w_old_way;
        w_evict = 1'b1;
      end
    end
  end

  always_comb begin
    w_vld_new        = w_vld;
    w_vld_new[w_sel] = !r_inval;
  end

  lru_rank_update #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_rank_update (
    .i_rank  (w_rank),
    .i_way   (w_sel),
    .i_inval (r_inval),
    .o_rank  (w_rank_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          r_rank[s][w] <= WAY_W'(w);
      r_valid <= '0;
    end else if (r_state == CALC && w_upd) begin
      r_rank[r_set]  <= w_rank_new;
      r_valid[r_set] <= w_vld_new;
    end
  end

  // Response fields only move at CALC-end, so they hold through any RESP stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_way   <= '0;
      r_resp_evict <= 1'b0;
      r_resp_err   <= 1'b0;
    end else if (r_state == CALC) begin
      r_resp_way   <= w_sel;
      r_resp_evict <= w_evict;
      r_resp_err   <= w_err;
    end
  end

`ifdef LRU_STATS_EN
  logic [31:0] r_hits, r_misses, r_evicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_evicts <= '0;
    end else if (r_state == CALC && !r_inval) begin
      if (r_hit && !w_err && r_hits != '1)  r_hits   <= r_hits + 32'd1;
      if (!r_hit && r_misses != '1)         r_misses <= r_misses + 32'd1;
      if (w_evict && r_evicts != '1)        r_evicts <= r_evicts + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
  assign stat_evicts = r_evicts;
`endif

endmodule
